div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have ports: rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports: in_valid  input  1; in_ready  output  1; in_dividend  input  WIDTH; in_divisor  input  WIDTH  (operand pair accepted on in_valid && in_ready).
REQ-005 SHALL have ports: div_start  output  1; div_dividend  output  WIDTH; div_divisor  output  WIDTH  (drive the divider controller's start and datapath load inputs).
REQ-006 SHALL have ports: div_ready  input  1; div_quotient  input  WIDTH; div_remainder  input  WIDTH  (divider idle flag and results).
REQ-007 SHALL have ports: out_valid  output  1; out_ready  input  1; out_quotient  output  WIDTH; out_remainder  output  WIDTH; out_dbz  output  1  (result transferred on out_valid && out_ready).

Function
REQ-008 SHALL buffer accepted operand pairs in a 2-entry FIFO, in order.
REQ-009 SHALL compute in_ready = rst && (FIFO not full); in_ready SHALL NOT depend on a same-cycle pop.
REQ-010 SHALL implement the FSM states IDLE, START, WAIT_BUSY, WAIT_DONE and DONE.
REQ-011 IDLE: when the FIFO is not empty and div_ready=1, the FSM SHALL pop the head entry into operand registers and go to START, or to DONE under REQ-017.
REQ-012 START: div_start SHALL be 1 for exactly this one cycle; the FSM SHALL then go to WAIT_BUSY.
REQ-013 WAIT_BUSY: the FSM SHALL stay until div_ready=0, then go to WAIT_DONE.
REQ-014 WAIT_DONE: when div_ready=1, the block SHALL capture div_quotient and div_remainder into the output registers, clear out_dbz, and go to DONE.
REQ-015 DONE: out_valid SHALL be 1; on out_ready=1 the FSM SHALL return to IDLE in the next cycle. While out_valid=1 and out_ready=0, the out_* outputs SHALL be held stable.
REQ-016 div_dividend and div_divisor SHALL come directly from the operand registers and SHALL remain stable from the pop until the FSM leaves WAIT_DONE.
REQ-017 With the REQ-024 macro defined, a popped divisor of 0 SHALL bypass the divider: out_quotient = all ones, out_remainder = dividend, out_dbz = 1, next state DONE, and div_start stays 0.
REQ-018 Latency: pair pushed at cycle t into an empty FIFO with the FSM idle SHALL be popped at t+1; the bypass result SHALL show out_valid=1 at t+2.
REQ-019 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged; a push while full SHALL be impossible (in_ready=0).
REQ-020 FIFO read and write pointers SHALL wrap modulo 2.

Reset
REQ-021 While rst=0 at a clk edge: FSM -> IDLE; FIFO empty; operand and output registers -> 0; div_start, out_valid, out_dbz -> 0; in_ready = 0 while rst=0.
REQ-022 Reset SHALL NOT drive the divider. After reset mid-operation, the FSM SHALL wait in IDLE for div_ready=1 before issuing, so that any in-flight division's result is discarded.

Configuration
REQ-023 Exactly one feature SHALL be configurable by a macro, the divide-by-zero bypass of REQ-017.
REQ-024 With DIV_SEQ_DBZ_CHECK_EN defined, REQ-017 SHALL apply.
REQ-025 Without DIV_SEQ_DBZ_CHECK_EN, a zero divisor SHALL be issued to the divider like any other operand, and out_dbz SHALL be constant 0.

Verification
REQ-026 Push 100/7 with out_ready=1 -> one div_start pulse; out_quotient=14, out_remainder=2, out_dbz=0.
REQ-027 Push 255/16, 200/3 and 9/9 back-to-back with the divider busy -> in_ready=0 after two pushes; results 15r15, 66r2, 1r0 appear in order.
REQ-028 With the macro defined, push 42/0 -> out_valid at t+2; out_quotient=0xFF, out_remainder=42, out_dbz=1; no div_start.
REQ-029 Result 100/7 with out_ready held 0 for 5 cycles -> out_* stable for 5 cycles; exactly one transfer when out_ready=1.
REQ-030 Assert rst=0 for 1 cycle during WAIT_DONE -> outputs cleared; no out_valid for the aborted pair; the next pushed pair 50/5 gives 10r0.

Source files
------------

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
//
// Feeds operand pairs to an external iterative divider controller and presents
// the results on a valid/ready output channel. A 2-entry in-order FIFO decouples
// the producer from the divider. A small FSM issues one division at a time.
//
// Optional feature (compile-time macro DIV_SEQ_DBZ_CHECK_EN):
//   A popped divisor of zero bypasses the divider. The result is
//   quotient = all ones, remainder = dividend, out_dbz = 1.
//   Without the macro, zero divisors go to the divider like any other
//   operand, and out_dbz is tied to 0.
//
// Ports
//   clk            rising-edge clock; the only clock
//   rst            synchronous reset, active low
//   in_valid/in_ready, in_dividend, in_divisor   operand input channel
//   div_start      one-cycle start pulse to the divider
//   div_dividend, div_divisor   operands for the divider (from operand regs)
//   div_ready      divider idle flag
//   div_quotient, div_remainder   divider results
//   out_valid/out_ready, out_quotient, out_remainder, out_dbz   result channel
// -----------------------------------------------------------------------------
module div_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   output logic             div_start,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   input  logic             div_ready,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             out_dbz
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE,
      DONE
   } state_t;

   state_t state_q, state_d;

   // FIFO storage, pointers and occupancy
   logic [WIDTH-1:0] fifo_dvd_q [2];
   logic [WIDTH-1:0] fifo_dvs_q [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             push;
   logic             pop;

   // Operand and result registers
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;

`ifdef DIV_SEQ_DBZ_CHECK_EN
   logic dbz_q, dbz_d;
`endif

   // in_ready looks only at registered occupancy so it never depends on a
   // pop happening in the same cycle.
   assign in_ready = rst && (count_q != 2'd2);
   assign push     = in_valid && in_ready;

   // FIFO entries carry no reset; occupancy alone says which are meaningful.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk) begin
         if (push && (wr_ptr_q == 1'(gi))) begin
            fifo_dvd_q[gi] <= in_dividend;
            fifo_dvs_q[gi] <= in_divisor;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      pop     = 1'b0;
`ifdef DIV_SEQ_DBZ_CHECK_EN
      dbz_d   = dbz_q;
`endif
      case (state_q)
         IDLE: begin
            // Waiting for div_ready also drains any division left running
            // by a reset, so its result is never picked up.
            if ((count_q != 2'd0) && div_ready) begin
               pop     = 1'b1;
               opa_d   = fifo_dvd_q[rd_ptr_q];
               opb_d   = fifo_dvs_q[rd_ptr_q];
               state_d = START;
`ifdef DIV_SEQ_DBZ_CHECK_EN
               if (fifo_dvs_q[rd_ptr_q] == '0) begin
                  quo_d   = '1;
                  rem_d   = fifo_dvd_q[rd_ptr_q];
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end
`endif
            end
         end
         START: state_d = WAIT_BUSY;
         WAIT_BUSY: begin
            if (!div_ready) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (div_ready) begin
               quo_d   = div_quotient;
               rem_d   = div_remainder;
`ifdef DIV_SEQ_DBZ_CHECK_EN
               dbz_d   = 1'b0;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pointers are one bit wide, so toggling is the modulo-2 wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         opa_q    <= '0;
         opb_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
`ifdef DIV_SEQ_DBZ_CHECK_EN
         dbz_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
`ifdef DIV_SEQ_DBZ_CHECK_EN
         dbz_q    <= dbz_d;
`endif
      end
   end

   assign div_start     = (state_q == START);
   assign div_dividend  = opa_q;
   assign div_divisor   = opb_q;
   assign out_valid     = (state_q == DONE);
   assign out_quotient  = quo_q;
   assign out_remainder = rem_q;
`ifdef DIV_SEQ_DBZ_CHECK_EN
   assign out_dbz       = dbz_q;
`else
   assign out_dbz       = 1'b0;
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_sequencer
//
// Self-checking bench for div_sequencer. A behavioural divider controller
// answers div_start after a fixed latency. A negedge monitor collects every
// result transfer into a queue. Directed vectors run from a table, then
// hand-written sequences cover the multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_div_sequencer;
   localparam int W       = 8;
   localparam int DIV_LAT = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_dividend = '0;
   logic [W-1:0] in_divisor  = '0;
   logic         div_start;
   logic [W-1:0] div_dividend;
   logic [W-1:0] div_divisor;
   logic         div_ready;
   logic [W-1:0] div_quotient  = '0;
   logic [W-1:0] div_remainder = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_quotient;
   logic [W-1:0] out_remainder;
   logic         out_dbz;

   always #5 clk = ~clk;

   div_sequencer #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_dividend   (in_dividend),
      .in_divisor    (in_divisor),
      .div_start     (div_start),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_ready     (div_ready),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_quotient  (out_quotient),
      .out_remainder (out_remainder),
      .out_dbz       (out_dbz)
   );

   // Behavioural divider controller; it ignores rst, like the real one.
   logic         dv_busy  = 1'b0;
   logic         ext_busy = 1'b0;
   int           dv_cnt   = 0;
   logic [W-1:0] dv_a = '0;
   logic [W-1:0] dv_b = '0;
   assign div_ready = !dv_busy && !ext_busy;

   always @(posedge clk) begin
      if (dv_busy) begin
         if (dv_cnt == 0) begin
            dv_busy <= 1'b0;
            if (dv_b == '0) begin
               div_quotient  <= '1;
               div_remainder <= dv_a;
            end else begin
               div_quotient  <= dv_a / dv_b;
               div_remainder <= dv_a % dv_b;
            end
         end else begin
            dv_cnt <= dv_cnt - 1;
         end
      end else if (div_start && div_ready) begin
         dv_busy <= 1'b1;
         dv_cnt  <= DIV_LAT;
         dv_a    <= div_dividend;
         dv_b    <= div_divisor;
      end
   end

   // Monitor: result transfers and start pulses.
   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } res_t;

   res_t res_q[$];
   int   start_cnt = 0;

   always @(negedge clk) begin
      if (div_start) start_cnt++;
      if (rst && out_valid && out_ready) res_q.push_back({out_quotient, out_remainder, out_dbz});
   end

   int check_cnt = 0;
   int pass_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic fail_timeout(input string name);
      check_cnt++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         fail_timeout("push_in_ready");
      end else begin
         in_valid    = 1'b1;
         in_dividend = a;
         in_divisor  = b;
         @(posedge clk);
         #1;
         in_valid    = 1'b0;
         $display("push %0d/%0d", a, b);
      end
   endtask

   task automatic get_result(input string name, output res_t r);
      int n = 0;
      while (res_q.size() == 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (res_q.size() == 0) begin
         fail_timeout(name);
         r = '0;
      end else begin
         r = res_q.pop_front();
         $display("result %s q=%0d r=%0d dbz=%0d", name, r.q, r.r, r.dbz);
      end
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           starts;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t r;
      res_t snap;
      int   s0;
      int   n;

      vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 1};
      vecs[1] = '{8'd255, 8'd16,  8'd15,  8'd15, 1'b0, 1};
      vecs[2] = '{8'd200, 8'd3,   8'd66,  8'd2,  1'b0, 1};
      vecs[3] = '{8'd9,   8'd9,   8'd1,   8'd0,  1'b0, 1};
      vecs[4] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 1};
      vecs[5] = '{8'd5,   8'd200, 8'd0,   8'd5,  1'b0, 1};
      vecs[6] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 1};
`ifdef DIV_SEQ_DBZ_CHECK_EN
      vecs[7] = '{8'd42,  8'd0,   8'd255, 8'd42, 1'b1, 0};
`else
      vecs[7] = '{8'd42,  8'd0,   8'd255, 8'd42, 1'b0, 1};
`endif

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_div_start", div_start, 0);
      check("rst_out_dbz", out_dbz, 0);
      check("rst_out_q", out_quotient, 0);
      check("rst_out_r", out_remainder, 0);
      check("rst_div_dividend", div_dividend, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);

      // First-transaction latency: pop at t+1, then DONE (bypass) or START at t+2
      push(8'd42, 8'd0);
      @(negedge clk);
      check("lat_t1_out_valid", out_valid, 0);
      check("lat_t1_div_start", div_start, 0);
      @(negedge clk);
`ifdef DIV_SEQ_DBZ_CHECK_EN
      check("lat_t2_out_valid", out_valid, 1);
      check("lat_t2_div_start", div_start, 0);
`else
      check("lat_t2_div_start", div_start, 1);
`endif
      get_result("lat_42_0", r);
      check("lat_42_0_q", r.q, 8'hFF);
      check("lat_42_0_r", r.r, 42);

      // Table-driven single transactions
      for (int i = 0; i < 8; i++) begin
         s0 = start_cnt;
         push(vecs[i].a, vecs[i].b);
         get_result($sformatf("vec%0d", i), r);
         check($sformatf("vec%0d_q", i), r.q, vecs[i].q);
         check($sformatf("vec%0d_r", i), r.r, vecs[i].r);
         check($sformatf("vec%0d_dbz", i), r.dbz, vecs[i].dbz);
         check($sformatf("vec%0d_starts", i), start_cnt - s0, vecs[i].starts);
      end

      // Divider busy: FIFO fills after two pushes, results stay in order
      @(negedge clk);
      ext_busy = 1'b1;
      s0 = start_cnt;
      push(8'd255, 8'd16);
      push(8'd200, 8'd3);
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
      check("full_no_start", start_cnt - s0, 0);
      ext_busy = 1'b0;
      push(8'd9, 8'd9);
      get_result("burst0", r);
      check("burst0_qr", {r.q, r.r}, {8'd15, 8'd15});
      get_result("burst1", r);
      check("burst1_qr", {r.q, r.r}, {8'd66, 8'd2});
      get_result("burst2", r);
      check("burst2_qr", {r.q, r.r}, {8'd1, 8'd0});
      check("burst_starts", start_cnt - s0, 3);

      // Output back-pressure: held stable for 5 cycles, one transfer on release
      out_ready = 1'b0;
      push(8'd100, 8'd7);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) fail_timeout("stall_out_valid");
      snap = {out_quotient, out_remainder, out_dbz};
      check("stall_snap_qr", {snap.q, snap.r}, {8'd14, 8'd2});
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("stall_hold%0d", k), {out_valid, out_quotient, out_remainder, out_dbz}, {1'b1, snap});
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("stall_transfers", res_q.size(), 1);
      check("stall_out_valid_after", out_valid, 0);
      get_result("stall", r);
      check("stall_result_qr", {r.q, r.r}, {8'd14, 8'd2});

      // Reset during WAIT_DONE: aborted result discarded, next pair still correct
      push(8'd100, 8'd7);
      n = 0;
      while (!div_start && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!div_start) fail_timeout("abort_div_start");
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("abort_out_valid", out_valid, 0);
      check("abort_out_q", out_quotient, 0);
      check("abort_div_dividend", div_dividend, 0);
      check("abort_div_start", div_start, 0);
      push(8'd50, 8'd5);
      get_result("after_abort", r);
      check("after_abort_qr", {r.q, r.r}, {8'd10, 8'd0});
      repeat (10) @(negedge clk);
      check("after_abort_extra", res_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
